// File: rtl/ibex_mem_responder_pkg.sv
// Shared types and helpers for the Ibex bus memory responder.
// Response bundle, outstanding-count width and address decode.
package ibex_mem_responder_pkg;

    localparam int unsigned OutstW = 3;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } mem_rsp_t;

    function automatic logic addr_in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned words
    );
        logic [33:0] off;
        logic [33:0] span;
        off  = {2'b00, addr - base};
        span = {2'b00, words} << 2;
        return (addr >= base) && (off < span);
    endfunction

endpackage

// File: rtl/ibex_mem_responder_pipe.sv
// Fixed-latency response pipeline for the memory responder.
// Only valid bits are reset; payload is zeroed at the output.
module ibex_mem_responder_pipe
    import ibex_mem_responder_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  mem_rsp_t rsp_i,
    output mem_rsp_t rsp_o
);

    logic [Depth-1:0] valid_q;
    logic [32:0]      data_q [Depth];

    // Valid bits shift towards the output; cleared on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= rsp_i.valid;
            for (int i = 1; i < Depth; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Payload follows the valid bits without reset.
    always_ff @(posedge clk_i) begin
        data_q[0] <= {rsp_i.err, rsp_i.rdata};
        for (int i = 1; i < Depth; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    // Present the last stage, zero when nothing is valid.
    always_comb begin
        rsp_o = '0;
        if (valid_q[Depth-1]) begin
            rsp_o.valid = 1'b1;
            rsp_o.err   = data_q[Depth-1][32];
            rsp_o.rdata = data_q[Depth-1][31:0];
        end
    end

endmodule

// File: rtl/ibex_mem_responder.sv
// Memory-side responder for the Ibex req/gnt/rvalid bus.
// Word RAM, decode, grant throttling and response counting.
module ibex_mem_responder
    import ibex_mem_responder_pkg::*;
#(
    parameter int unsigned MemWords       = 4096,
    parameter logic [31:0] BaseAddr       = 32'h00100000,
    parameter int unsigned RspLatency     = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    input  logic              stall_i,
    output logic [OutstW-1:0] outstanding_o
);

    localparam int unsigned IdxW = $clog2(MemWords);
    localparam logic [OutstW-1:0] MaxOut = OutstW'(MaxOutstanding);

    logic [31:0]       mem [MemWords];
    logic [OutstW-1:0] outstanding_q;
    logic [OutstW-1:0] outstanding_d;
    logic [IdxW-1:0]   idx;
    logic              in_range;
    logic              grant;
    logic              retire;
    logic              room;
    mem_rsp_t          rsp_in;
    mem_rsp_t          rsp_out;

    assign in_range = addr_in_range(addr_i, BaseAddr, MemWords);
    assign idx      = IdxW'((addr_i - BaseAddr) >> 2);
    assign retire   = rsp_out.valid;

    // A retiring response frees its slot in the same cycle.
    assign room  = (outstanding_q < MaxOut)
                 | (retire & (outstanding_q == MaxOut));
    assign gnt_o = req_i & ~stall_i & room;
    assign grant = req_i & gnt_o;

    // Build the response captured at the grant edge.
    always_comb begin
        rsp_in       = '0;
        rsp_in.valid = grant;
        rsp_in.err   = ~in_range;
        if (in_range && !we_i) begin
            rsp_in.rdata = mem[idx];
        end
    end

    // Byte-lane writes land at the grant edge; RAM is never reset.
    always_ff @(posedge clk_i) begin
        if (grant && we_i && in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Next pending count: grants add, responses retire.
    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({grant, retire})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Pending-response counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    ibex_mem_responder_pipe #(
        .Depth (RspLatency)
    ) u_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .rsp_i  (rsp_in),
        .rsp_o  (rsp_out)
    );

    assign rvalid_o      = rsp_out.valid;
    assign rdata_o       = rsp_out.rdata;
    assign err_o         = rsp_out.err;
    assign outstanding_o = outstanding_q;

    a_out_max: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        outstanding_q <= MaxOut);

    a_out_min: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        retire |-> (outstanding_q != '0));

    a_no_x: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !$isunknown({gnt_o, rvalid_o}));

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Bench for the Ibex memory responder: two instances,
// latency 1 and latency 3, checked against a scoreboard.
module tb_ibex_mem_responder;

    localparam logic [31:0] BASE = 32'h00100000;
    localparam logic [31:0] LIM  = 32'h00104000;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req   [2];
    logic        we    [2];
    logic        stall [2];
    logic [3:0]  be    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        gnt   [2];
    logic        rvalid[2];
    logic        errs  [2];
    logic [31:0] rdata [2];
    logic [2:0]  outs  [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gq[$];
    logic [31:0] mdl [longint];

    ibex_mem_responder u_dut0 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req[0]),
        .gnt_o         (gnt[0]),
        .we_i          (we[0]),
        .be_i          (be[0]),
        .addr_i        (addr[0]),
        .wdata_i       (wdata[0]),
        .rvalid_o      (rvalid[0]),
        .rdata_o       (rdata[0]),
        .err_o         (errs[0]),
        .stall_i       (stall[0]),
        .outstanding_o (outs[0])
    );

    ibex_mem_responder #(
        .RspLatency     (3),
        .MaxOutstanding (2)
    ) u_dut1 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req[1]),
        .gnt_o         (gnt[1]),
        .we_i          (we[1]),
        .be_i          (be[1]),
        .addr_i        (addr[1]),
        .wdata_i       (wdata[1]),
        .rvalid_o      (rvalid[1]),
        .rdata_o       (rdata[1]),
        .err_o         (errs[1]),
        .stall_i       (stall[1]),
        .outstanding_o (outs[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    for (genvar g = 0; g < 2; g++) begin : mon
        localparam int Lat = (g == 0) ? 1 : 3;
        exp_t        q[$];
        logic [31:0] last_rdata = '0;
        logic        last_err = 1'b0;
        int          max_out = 0;
        int          rv_cnt = 0;

        always @(negedge clk) begin
            exp_t        e;
            longint      key;
            logic [31:0] v;
            if (!rst_n) begin
                q.delete();
            end else begin
                checks++;
                assert (outs[g] === 3'(q.size())) else begin
                    errors++;
                    $error("FAIL outstanding%0d: observed %0d expected %0d",
                           g, outs[g], q.size());
                end
                if (int'(outs[g]) > max_out) max_out = int'(outs[g]);
                if (rvalid[g]) begin
                    rv_cnt++;
                    checks++;
                    assert (q.size() != 0) else begin
                        errors++;
                        $error("FAIL stray_rvalid%0d: observed 1 expected 0", g);
                    end
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        checks++;
                        assert ({errs[g], rdata[g]} === {e.err, e.rdata}) else begin
                            errors++;
                            $error("FAIL rsp%0d: observed %b/%h expected %b/%h",
                                   g, errs[g], rdata[g], e.err, e.rdata);
                        end
                        checks++;
                        assert (cyc - e.cyc == Lat) else begin
                            errors++;
                            $error("FAIL latency%0d: observed %0d expected %0d",
                                   g, cyc - e.cyc, Lat);
                        end
                        last_rdata = rdata[g];
                        last_err   = errs[g];
                    end
                end else begin
                    checks++;
                    assert ({errs[g], rdata[g]} === 33'b0) else begin
                        errors++;
                        $error("FAIL idle%0d: observed %b/%h expected 0/0",
                               g, errs[g], rdata[g]);
                    end
                end
                if (req[g] && gnt[g]) begin
                    key = (longint'(g) << 32)
                        | longint'(addr[g] & 32'hFFFF_FFFC);
                    e.cyc   = cyc;
                    e.err   = 1'b0;
                    e.rdata = '0;
                    if (addr[g] < BASE || addr[g] >= LIM) begin
                        e.err = 1'b1;
                    end else if (we[g]) begin
                        v = mdl.exists(key) ? mdl[key] : 32'h0;
                        for (int k = 0; k < 4; k++)
                            if (be[g][k]) v[8*k +: 8] = wdata[g][8*k +: 8];
                        mdl[key] = v;
                    end else begin
                        e.rdata = mdl.exists(key) ? mdl[key] : 32'h0;
                    end
                    q.push_back(e);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] b,
                         output int waited);
        logic got;
        got = 1'b0;
        waited = 0;
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
        while (!got && waited < 50) begin
            @(negedge clk);
            if (gnt[d]) got = 1'b1;
            else waited++;
        end
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL grant_timeout%0d: observed none expected gnt", d);
        end
        @(posedge clk); #1;
        req[d] = 1'b0; we[d] = 1'b0;
    endtask

    task automatic burst(input int n, input logic [31:0] a0,
                         input int slo, input int shi);
        int k;
        int got;
        k = 0;
        got = 0;
        gq.delete();
        req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'h0; addr[1] = a0;
        while (got < n && k < 100) begin
            stall[1] = (k >= slo && k <= shi);
            @(negedge clk);
            if (gnt[1]) begin
                gq.push_back(k);
                got++;
            end
            @(posedge clk); #1;
            addr[1] = a0 + 32'(4 * got);
            k++;
        end
        req[1] = 1'b0; stall[1] = 1'b0;
        checks++;
        assert (got == n) else begin
            errors++;
            $error("FAIL burst_timeout: observed %0d expected %0d", got, n);
        end
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int base_rv;
        int exp_burst[6] = '{0, 1, 3, 4, 6, 7};
        int exp_stall[4] = '{0, 1, 6, 7};
        for (int d = 0; d < 2; d++) begin
            req[d] = 0; we[d] = 0; stall[d] = 0;
            be[d] = '0; addr[d] = '0; wdata[d] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_gnt", 32'(gnt[d]), 32'h0);
            chk("rst_rvalid", 32'(rvalid[d]), 32'h0);
            chk("rst_err", 32'(errs[d]), 32'h0);
            chk("rst_rdata", rdata[d], 32'h0);
            chk("rst_out", 32'(outs[d]), 32'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(0, 1, 32'h00100010, 32'hDEADBEEF, 4'hF, w);
        chk("wr_gnt_wait", 32'(w), 32'h0);
        issue(0, 0, 32'h00100010, 32'h0, 4'h0, w);
        chk("rd_gnt_wait", 32'(w), 32'h0);
        settle();
        chk("rd_deadbeef", mon[0].last_rdata, 32'hDEADBEEF);
        chk("rd_deadbeef_err", 32'(mon[0].last_err), 32'h0);

        issue(0, 1, 32'h00100020, 32'hFFFFFFFF, 4'hF, w);
        issue(0, 1, 32'h00100020, 32'h11223344, 4'b0101, w);
        issue(0, 0, 32'h00100020, 32'h0, 4'h0, w);
        settle();
        chk("partial", mon[0].last_rdata, 32'hFF22FF44);

        issue(0, 0, 32'h00000000, 32'h0, 4'h0, w);
        settle();
        chk("below_err", 32'(mon[0].last_err), 32'h1);
        chk("below_rdata", mon[0].last_rdata, 32'h0);
        issue(0, 0, 32'h00104000, 32'h0, 4'h0, w);
        settle();
        chk("past_err", 32'(mon[0].last_err), 32'h1);
        chk("past_rdata", mon[0].last_rdata, 32'h0);
        issue(0, 1, 32'h00100010, 32'h0, 4'h0, w);
        issue(0, 0, 32'h00100010, 32'h0, 4'h0, w);
        settle();
        chk("be0_noop", mon[0].last_rdata, 32'hDEADBEEF);
        chk("after_err", 32'(mon[0].last_err), 32'h0);
        issue(0, 1, 32'h00103FFC, 32'hCAFEF00D, 4'hF, w);
        issue(0, 0, 32'h00103FFF, 32'h0, 4'h0, w);
        settle();
        chk("last_word", mon[0].last_rdata, 32'hCAFEF00D);

        for (int i = 0; i < 6; i++)
            issue(1, 1, 32'h00100100 + 32'(4 * i),
                  32'hC0DE0000 + 32'(i), 4'hF, w);
        settle();
        burst(6, 32'h00100100, -1, -1);
        settle();
        chk("burst_n", 32'(gq.size()), 32'd6);
        for (int i = 0; i < 6 && i < gq.size(); i++)
            chk("burst_gnt_cyc", 32'(gq[i]), 32'(exp_burst[i]));
        chk("burst_max_out", 32'(mon[1].max_out), 32'd2);
        chk("burst_last", mon[1].last_rdata, 32'hC0DE0005);

        burst(4, 32'h00100104, 2, 5);
        settle();
        chk("stall_n", 32'(gq.size()), 32'd4);
        for (int i = 0; i < 4 && i < gq.size(); i++)
            chk("stall_gnt_cyc", 32'(gq[i]), 32'(exp_stall[i]));
        chk("stall_last", mon[1].last_rdata, 32'hC0DE0004);

        burst(2, 32'h00100108, -1, -1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base_rv = mon[1].rv_cnt;
        @(negedge clk);
        chk("rst_mid_out", 32'(outs[1]), 32'h0);
        repeat (6) @(posedge clk);
        #1;
        chk("rst_mid_rv", 32'(mon[1].rv_cnt - base_rv), 32'h0);
        issue(1, 0, 32'h0010010C, 32'h0, 4'h0, w);
        settle();
        chk("persist1", mon[1].last_rdata, 32'hC0DE0003);
        issue(0, 0, 32'h00100020, 32'h0, 4'h0, w);
        settle();
        chk("persist0", mon[0].last_rdata, 32'hFF22FF44);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
